// File: rtl/led_share_scheduler.sv
// led_share_scheduler: round-robin owner of the board LED bank.
// A granted requester's latched pattern is shown for HOLD_TICKS ticks,
// followed by a one-cycle blank gap; with no requester active the bank
// runs a one-hot chase that advances every CHASE_TICKS ticks.
module led_share_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LED_W       = 4,
    parameter int TICK_DIV    = 50_000_000,
    parameter int HOLD_TICKS  = 2,
    parameter int CHASE_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LED_W-1:0]   req_pattern,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       done,
    output logic                       busy,
    output logic [LED_W-1:0]           led
);

    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int HC_W  = $clog2(HOLD_TICKS + 1);
    localparam int CC_W  = $clog2(CHASE_TICKS + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CP_W  = (LED_W > 1) ? $clog2(LED_W) : 1;

    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(TICK_DIV - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD_TICKS - 1);
    localparam logic [CC_W-1:0]  CHASE_LAST = CC_W'(CHASE_TICKS - 1);
    localparam logic [CP_W-1:0]  POS_LAST   = CP_W'(LED_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Registered state
    state_t             r_state;
    logic [PS_W-1:0]    r_presc;
    logic [HC_W-1:0]    r_hold_cnt;
    logic [CC_W-1:0]    r_chase_cnt;
    logic [CP_W-1:0]    r_chase_pos;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_done;
    logic               r_busy;
    logic [LED_W-1:0]   r_led;

    // Next-state values
    state_t             w_state_nxt;
    logic [PS_W-1:0]    w_presc_nxt;
    logic [HC_W-1:0]    w_hold_cnt_nxt;
    logic [CC_W-1:0]    w_chase_cnt_nxt;
    logic [CP_W-1:0]    w_chase_pos_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;
    logic [LED_W-1:0]   w_led_nxt;

    // Combinational helpers
    logic               w_tick;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [LED_W-1:0]   w_win_pat;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [LED_W-1:0]   w_chase_led;
    logic [LED_W-1:0]   w_pat [NUM_REQ];

    assign w_tick = (r_presc == PS_LAST);

    // Unpack the flat pattern bus into one slot per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pat
        assign w_pat[g] = req_pattern[g*LED_W +: LED_W];
    end

    // Round-robin search: first set request after the last owner, wrapping
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_winner  = '0;
        w_win_pat = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[IDX_W'(idx)]) begin
                w_found   = 1'b1;
                w_winner  = IDX_W'(idx);
                w_win_pat = w_pat[IDX_W'(idx)];
            end
        end
    end

    // One-hot decodes of the arbitration winner and the chase position
    always_comb begin
        w_win_onehot           = '0;
        w_win_onehot[w_winner] = 1'b1;
        w_chase_led              = '0;
        w_chase_led[r_chase_pos] = 1'b1;
    end

    // Next-state and registered-output logic for IDLE / SHOW / GAP
    always_comb begin
        w_state_nxt     = r_state;
        w_presc_nxt     = w_tick ? '0 : r_presc + 1'b1;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_chase_cnt_nxt = r_chase_cnt;
        w_chase_pos_nxt = r_chase_pos;
        w_last_nxt      = r_last;
        w_grant_nxt     = r_grant;
        w_done_nxt      = r_done;
        w_busy_nxt      = r_busy;
        w_led_nxt       = r_led;

        case (r_state)
            IDLE: begin
                w_led_nxt = w_chase_led;
                // Chase counters only move while idle, so they resume
                // from where they froze when a grant interrupted them.
                if (w_tick) begin
                    if (r_chase_cnt == CHASE_LAST) begin
                        w_chase_cnt_nxt = '0;
                        w_chase_pos_nxt = (r_chase_pos == POS_LAST) ? '0
                                                                    : r_chase_pos + 1'b1;
                    end else begin
                        w_chase_cnt_nxt = r_chase_cnt + 1'b1;
                    end
                end
                if (w_found) begin
                    w_grant_nxt    = w_win_onehot;
                    w_busy_nxt     = 1'b1;
                    w_led_nxt      = w_win_pat;
                    w_last_nxt     = w_winner;
                    w_hold_cnt_nxt = '0;
                    // Restart the prescaler so the hold is a whole number
                    // of ticks measured from the grant edge.
                    w_presc_nxt    = '0;
                    w_state_nxt    = SHOW;
                end
            end

            SHOW: begin
                // led keeps the pattern captured at grant time.
                if (!req[r_last]) begin
                    // Abandon takes priority over a coincident normal end.
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_led_nxt   = '0;
                    w_state_nxt = GAP;
                end else if (w_tick) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_grant_nxt = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_led_nxt   = '0;
                        w_state_nxt = GAP;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end

            GAP: begin
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
                // The arbitration cycle shows the chase only when nobody
                // is waiting; otherwise it stays blank until the grant.
                w_led_nxt   = (req == '0) ? w_chase_led : '0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, arbitration pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_hold_cnt  <= '0;
            r_chase_cnt <= '0;
            r_chase_pos <= '0;
            r_last      <= IDX_LAST;
            r_grant     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_led       <= '0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_chase_cnt <= w_chase_cnt_nxt;
            r_chase_pos <= w_chase_pos_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign led   = r_led;

endmodule

// File: tb/tb_led_share_scheduler.sv
// Directed bench for led_share_scheduler with TICK_DIV=4, HOLD_TICKS=2,
// CHASE_TICKS=1, NUM_REQ=4, LED_W=4. Expected values are hand-derived.
module tb_led_share_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int LED_W       = 4;
    localparam int TICK_DIV    = 4;
    localparam int HOLD_TICKS  = 2;
    localparam int CHASE_TICKS = 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_pattern;
    logic [NUM_REQ-1:0]       grant;
    logic                     done;
    logic                     busy;
    logic [LED_W-1:0]         led;

    int n_chk = 0;
    int n_err = 0;

    led_share_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LED_W      (LED_W),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS),
        .CHASE_TICKS(CHASE_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_pattern(req_pattern),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic d,
                           input logic b, input logic [3:0] l);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".led"},   32'(led),   32'(l));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input int i, input logic [3:0] p);
        req_pattern[i*LED_W +: LED_W] = p;
    endtask

    initial begin
        logic [3:0] pats [4];
        logic [3:0] eg;
        logic [3:0] el;
        int         p;
        int         o;
        int         dcount;

        rst_n       = 1'b0;
        req         = '0;
        req_pattern = '0;
        repeat (3) step();
        chk_out("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b1;

        // Idle chase: 0001 right after release, then one step per 4 cycles
        for (int i = 0; i < 17; i++) begin
            step();
            chk_out("chase", 4'b0000, 1'b0, 1'b0, 4'(1 << ((i / 4) % 4)));
        end

        // Single grant of requester 2
        req = 4'b0100;
        set_pat(2, 4'b1010);
        step();
        chk_out("grant2", 4'b0100, 1'b0, 1'b1, 4'b1010);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("hold2", 4'b0100, 1'b0, 1'b1, 4'b1010);
        end
        step();
        chk_out("done2", 4'b0000, 1'b1, 1'b0, 4'b0000);
        req = '0;
        step();
        chk_out("gap2", 4'b0000, 1'b0, 1'b0, 4'b0001);

        // Abandon by requester 1 while requester 3 waits
        req = 4'b0010;
        set_pat(1, 4'b0011);
        step();
        chk_out("grant1", 4'b0010, 1'b0, 1'b1, 4'b0011);
        req = 4'b1010;
        set_pat(3, 4'b1100);
        step();
        chk_out("own1a", 4'b0010, 1'b0, 1'b1, 4'b0011);
        step();
        chk_out("own1b", 4'b0010, 1'b0, 1'b1, 4'b0011);
        req = 4'b1000;
        step();
        chk_out("abandon1", 4'b0000, 1'b0, 1'b0, 4'b0000);
        step();
        chk_out("gap_wait", 4'b0000, 1'b0, 1'b0, 4'b0000);
        step();
        chk_out("grant3", 4'b1000, 1'b0, 1'b1, 4'b1100);
        req = '0;
        step();
        chk_out("abandon3", 4'b0000, 1'b0, 1'b0, 4'b0000);
        step();
        chk_out("chase_resume", 4'b0000, 1'b0, 1'b0, 4'b0001);

        // Pattern latched at grant time
        req = 4'b0001;
        set_pat(0, 4'b0110);
        step();
        chk_out("grant0", 4'b0001, 1'b0, 1'b1, 4'b0110);
        set_pat(0, 4'b1001);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("latch", 4'b0001, 1'b0, 1'b1, 4'b0110);
        end
        step();
        chk_out("done0", 4'b0000, 1'b1, 1'b0, 4'b0000);

        // Reset in the middle of requester 2's hold
        req = 4'b0100;
        step();
        chk_out("gap0", 4'b0000, 1'b0, 1'b0, 4'b0000);
        step();
        chk_out("grant2b", 4'b0100, 1'b0, 1'b1, 4'b1010);
        step();
        chk_out("hold2b", 4'b0100, 1'b0, 1'b1, 4'b1010);
        rst_n = 1'b0;
        step();
        chk_out("rst_mid", 4'b0000, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        req   = 4'b1101;
        step();
        chk_out("rr_first", 4'b0001, 1'b0, 1'b1, 4'b1001);

        // Round robin with every requester asserted
        pats[0] = 4'b1001;
        pats[1] = 4'b0011;
        pats[2] = 4'b1010;
        pats[3] = 4'b1100;
        req     = 4'b1111;
        dcount  = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            p  = j % 10;
            o  = (j / 10) % 4;
            eg = (p < 8) ? 4'(1 << o) : 4'b0000;
            el = (p < 8) ? pats[o] : 4'b0000;
            if (done === 1'b1) dcount++;
            chk_out("rr", eg, (p == 8), (p < 8), el);
        end
        chk("rr_done_count", 32'(dcount), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
